ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_key_decoder_if.sv | 19 +
 rtl/ps2_frame_rx.sv | 115 +++++++++++
 rtl/ps2_key_decoder.sv | 105 ++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: frame FSM encoding,
// scancodes of interest and direction bit positions.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_START = 8'h1B;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // One-hot direction mask for an arrow scancode (extended set), zero otherwise.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m[DIR_UP]    = 1'b1;
      SC_DOWN:  m[DIR_DOWN]  = 1'b1;
      SC_LEFT:  m[DIR_LEFT]  = 1'b1;
      SC_RIGHT: m[DIR_RIGHT] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Decoded key outputs of ps2_key_decoder plus the frame FSM state for debug.
// scan_valid is a one-cycle strobe with no back-pressure: scan_code is
// valid in that cycle and holds until the next decoded byte.
interface ps2_key_decoder_if;
  logic [3:0] direction;
  logic       start;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;
  logic [1:0] rx_state;

  modport master (
    output direction, start, scan_valid, scan_code, frame_err, rx_state
  );

  modport slave (
    input direction, start, scan_valid, scan_code, frame_err, rx_state
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: input synchronisers, falling-edge
// detect, 11-bit frame FSM with odd-parity/stop check and inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       err_o,
  output logic [1:0] state_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, dat_s, fall;

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // Stage 0 is the LSB; the synchronised value comes out of the MSB.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= (clk_sync_q << 1) | SYNC_STAGES'(ps2_clk_i);
      dat_sync_q <= (dat_sync_q << 1) | SYNC_STAGES'(ps2_dat_i);
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmo_d   = tmo_q;
    valid_o = 1'b0;
    err_o   = 1'b0;
    if (fall) begin
      // An edge always wins over a coincident timeout.
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!dat_s) begin
            state_d = ST_DATA;
            cnt_d   = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d = {dat_s, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_s;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if ((^{shift_q, par_q}) && dat_s) valid_o = 1'b1;
          else                              err_o   = 1'b1;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      shift_d = 8'h00;
      par_d   = 1'b0;
      tmo_d   = '0;
      err_o   = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  assign byte_o  = shift_q;
  assign state_o = state_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: tracks E0/F0 prefixes and maps arrow keys and S
// onto held direction/start levels.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               PS2_CLK,
  input  logic               PS2_DAT,
  ps2_key_decoder_if.master  key_if
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  logic [1:0] rx_state;
  logic [3:0] arrow_m;

  logic [3:0] dir_q, dir_d;
  logic       start_q, start_d;
  logic [7:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .ps2_clk_i (PS2_CLK),
    .ps2_dat_i (PS2_DAT),
    .byte_o    (rx_byte),
    .valid_o   (rx_valid),
    .err_o     (rx_err),
    .state_o   (rx_state)
  );

  assign arrow_m = arrow_mask(rx_byte);

  always_comb begin
    dir_d   = dir_q;
    start_d = start_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    ext_d   = ext_q;
    brk_d   = brk_q;
    if (rx_err) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = rx_byte;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        // Non-extended arrow codes are keypad keys and fall through unused.
        if (ext_q && (arrow_m != 4'b0000)) begin
          if (!brk_q)                          dir_d = arrow_m;
          else if ((dir_q & arrow_m) != 4'b0000) dir_d = 4'b0000;
        end else if (!ext_q && (rx_byte == SC_START)) begin
          start_d = ~brk_q;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dir_q   <= 4'b0000;
      start_q <= 1'b0;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      dir_q   <= dir_d;
      start_q <= start_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
    end
  end

  assign key_if.direction  = dir_q;
  assign key_if.start      = start_q;
  assign key_if.scan_code  = code_q;
  assign key_if.scan_valid = valid_q;
  assign key_if.frame_err  = err_q;
  assign key_if.rx_state   = rx_state;

endmodule
